// File: rtl/queue_pkg.sv
// Shared definitions for the bank queue system: counter, wait-time LUT and dispatcher.
package queue_pkg;

  localparam int unsigned MAX_QUEUE    = 7;
  localparam int unsigned MAX_TELLERS  = 3;
  localparam int unsigned P_COUNT_W    = 3;
  localparam int unsigned T_COUNT_W    = 2;
  localparam int unsigned TELLER_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    CALL
  } disp_state_t;

  // Next round-robin start position after idx, wrapping at n.
  function automatic logic [TELLER_IDX_W-1:0] rr_advance(
    input logic [TELLER_IDX_W-1:0] idx,
    input int unsigned             n
  );
    return ((32'(idx) + 32'd1) >= n) ? '0 : idx + TELLER_IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible teller at or after i_rr_ptr, wrapping.
module rr_arbiter
  import queue_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]            i_eligible,
  input  logic [TELLER_IDX_W-1:0] i_rr_ptr,
  output logic [TELLER_IDX_W-1:0] o_grant,
  output logic                    o_found
);

  logic [2*N-1:0]          w_dbl;
  logic [N-1:0]            w_rot;
  logic [TELLER_IDX_W-1:0] w_off;
  int unsigned             w_sum;

  // Rotate so bit 0 is the teller at rr_ptr; a plain priority scan then gives round-robin order.
  assign w_dbl = {i_eligible, i_eligible} >> i_rr_ptr;
  assign w_rot = w_dbl[N-1:0];

  // Find the lowest set bit of the rotated vector and map the offset back to a teller index.
  always_comb begin
    o_found = 1'b0;
    w_off   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!o_found && w_rot[k]) begin
        o_found = 1'b1;
        w_off   = TELLER_IDX_W'(k);
      end
    end
    w_sum   = 32'(i_rr_ptr) + 32'(w_off);
    o_grant = TELLER_IDX_W'((w_sum >= N) ? (w_sum - N) : w_sum);
  end

endmodule

// File: rtl/teller_dispatcher.sv
// Dispatcher: picks a free open teller round-robin, calls the front customer and
// waits for the front sensor (served) or a timeout (no-show).
module teller_dispatcher
  import queue_pkg::*;
#(
  parameter int unsigned N_TELLERS    = 3,
  parameter int unsigned CALL_TIMEOUT = 15,
  parameter int unsigned TOT_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [P_COUNT_W-1:0]    p_count,
  input  logic [T_COUNT_W-1:0]    t_count,
  input  logic                    taken,
  input  logic [N_TELLERS-1:0]    teller_done,
  output logic                    call_valid,
  output logic [TELLER_IDX_W-1:0] call_teller,
  output logic                    served,
  output logic                    no_show,
  output logic [N_TELLERS-1:0]    busy,
  output logic [TOT_W-1:0]        served_total
);

  localparam int unsigned TMR_W = (CALL_TIMEOUT > 2) ? $clog2(CALL_TIMEOUT) : 1;

  disp_state_t             r_state, w_state_nxt;
  logic [N_TELLERS-1:0]    r_busy, w_busy_nxt, w_elig;
  logic [TELLER_IDX_W-1:0] r_grant, r_rr_ptr, r_call_teller, w_arb_grant;
  logic [TMR_W-1:0]        r_timer;
  logic [TOT_W-1:0]        r_total;
  logic                    r_served, r_no_show, r_call_valid;
  logic                    w_found, w_timer_exp, w_accept, w_timeout, w_abort;

  // Teller i may be called when it is open (i < t_count) and not already serving.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < N_TELLERS; i++) begin
      w_elig[i] = (i < 32'(t_count)) && !r_busy[i];
    end
  end

  rr_arbiter #(.N(N_TELLERS)) u_arb (
    .i_eligible (w_elig),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_arb_grant),
    .o_found    (w_found)
  );

  assign w_timer_exp = (r_timer == TMR_W'(CALL_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; CALL exits on any of accept/timeout/abort.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if ((p_count != '0) && w_found) w_state_nxt = SELECT;
      SELECT:  w_state_nxt = w_found ? CALL : IDLE;
      CALL:    if (w_accept || w_timeout || w_abort) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // CALL outcome decode with priority taken > timeout > abort.
  always_comb begin
    w_accept   = (r_state == CALL) && taken;
    w_timeout  = (r_state == CALL) && !taken && w_timer_exp;
    w_abort    = (r_state == CALL) && !taken && !w_timer_exp &&
                 ((r_grant >= t_count) || (p_count == '0));
    w_busy_nxt = (r_busy & ~teller_done) |
                 (w_accept ? (N_TELLERS'(1) << r_grant) : '0);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy        <= '0;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_timer       <= '0;
      r_total       <= '0;
      r_served      <= 1'b0;
      r_no_show     <= 1'b0;
      r_call_valid  <= 1'b0;
      r_call_teller <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_served  <= w_accept;
      r_no_show <= w_timeout;
      if ((r_state == SELECT) && w_found) r_grant <= w_arb_grant;
      if ((r_state == CALL) && (w_state_nxt == CALL)) r_timer <= r_timer + TMR_W'(1);
      else                                            r_timer <= '0;
      if (w_accept || w_timeout) r_rr_ptr <= rr_advance(r_grant, N_TELLERS);
      if (w_accept) r_total <= r_total + TOT_W'(1);
      r_call_valid <= (w_state_nxt == CALL);
      // The grant register is loaded on the same edge CALL is entered, so take the arbiter value then.
      if (w_state_nxt == CALL) r_call_teller <= (r_state == SELECT) ? w_arb_grant : r_grant;
      else                     r_call_teller <= '0;
    end
  end

  assign call_valid   = r_call_valid;
  assign call_teller  = r_call_teller;
  assign served       = r_served;
  assign no_show      = r_no_show;
  assign busy         = r_busy;
  assign served_total = r_total;

endmodule
